// File: rtl/change_dispenser.sv
// Coin payout stage: splits a change amount greedily into 20/10/5 coins and
// releases them one at a time through a request/acknowledge coin hopper.
module change_dispenser #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] change_in,
  input  logic       change_valid,
  input  logic       eject_ack,
  output logic       eject_req,
  output logic [1:0] eject,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] remaining,
  output logic [3:0] coins_out
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TIMER_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PICK, REQ, GAP, DONE, FAULT} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    coin_reg, coin_next;
  logic [7:0]    remaining_reg, remaining_next;
  logic [3:0]    coins_reg, coins_next;
  logic          fault_reg, fault_next;
  logic [CW-1:0] timer_reg, timer_next;

  function automatic logic [7:0] coin_value(input logic [1:0] code);
    case (code)
      2'b01:   coin_value = 8'd5;
      2'b10:   coin_value = 8'd10;
      2'b11:   coin_value = 8'd20;
      default: coin_value = 8'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      coin_reg      <= 2'b00;
      remaining_reg <= 8'd0;
      coins_reg     <= 4'd0;
      fault_reg     <= 1'b0;
      timer_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      coin_reg      <= coin_next;
      remaining_reg <= remaining_next;
      coins_reg     <= coins_next;
      fault_reg     <= fault_next;
      timer_reg     <= timer_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    coin_next      = coin_reg;
    remaining_next = remaining_reg;
    coins_next     = coins_reg;
    fault_next     = fault_reg;
    timer_next     = timer_reg;
    unique case (state_reg)
      IDLE: begin
        if (change_valid && (change_in != 8'd0)) begin
          remaining_next = change_in;
          coins_next     = 4'd0;
          fault_next     = 1'b0;
          state_next     = PICK;
        end
      end
      PICK: begin
        // Largest coin that still fits; anything 1..4 cannot be paid out.
        if (remaining_reg >= 8'd20) begin
          coin_next  = 2'b11;
          state_next = REQ;
        end else if (remaining_reg >= 8'd10) begin
          coin_next  = 2'b10;
          state_next = REQ;
        end else if (remaining_reg >= 8'd5) begin
          coin_next  = 2'b01;
          state_next = REQ;
        end else if (remaining_reg == 8'd0) begin
          state_next = DONE;
        end else begin
          fault_next = 1'b1;
          state_next = FAULT;
        end
      end
      REQ: begin
        if (eject_ack) begin
          remaining_next = remaining_reg - coin_value(coin_reg);
          coins_next     = coins_reg + 4'd1;
          timer_next     = '0;
          state_next     = GAP;
        end else if (timer_reg == TIMER_LAST) begin
          timer_next = '0;
          fault_next = 1'b1;
          state_next = FAULT;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      GAP:     state_next = PICK;
      DONE:    state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign eject_req = (state_reg == REQ);
  assign eject     = (state_reg == REQ) ? coin_reg : 2'b00;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign fault     = fault_reg;
  assign remaining = remaining_reg;
  assign coins_out = coins_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser against a greedy-payout reference model.
module tb_change_dispenser;

  localparam int TO = 8;

  logic       clk, reset, change_valid, eject_ack, eject_req, busy, done, fault;
  logic [7:0] change_in, remaining;
  logic [1:0] eject;
  logic [3:0] coins_out;

  int checks = 0;
  int errors = 0;

  // Captured per transaction
  logic [1:0] got_coins[$];
  int         got_edges[$];
  int         done_cnt, done_edge, busy_fall, fault_edge, max_run;
  // Reference model output
  logic [1:0] exp_coins[$];
  int         exp_residue;

  change_dispenser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .change_in(change_in), .change_valid(change_valid),
    .eject_ack(eject_ack), .eject_req(eject_req), .eject(eject), .busy(busy),
    .done(done), .fault(fault), .remaining(remaining), .coins_out(coins_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Greedy decomposition by division: twenties, then tens, then fives.
  task automatic model(input int amt);
    int r;
    exp_coins.delete();
    r = amt;
    for (int i = 0; i < amt / 20; i++) exp_coins.push_back(2'b11);
    r = r % 20;
    for (int i = 0; i < r / 10; i++) exp_coins.push_back(2'b10);
    r = r % 10;
    for (int i = 0; i < r / 5; i++) exp_coins.push_back(2'b01);
    exp_residue = r % 5;
  endtask

  // Starts a transaction and observes it until busy falls. Edge n = state after
  // the n-th rising edge, edge 0 being the cycle in which change_valid is high.
  task automatic run_txn(input logic [7:0] amt, input int delay, input bit hold,
                         input int cv_edge, input int budget);
    int  n, age;
    logic prev;
    got_coins.delete(); got_edges.delete();
    done_cnt = 0; done_edge = -1; busy_fall = -1; fault_edge = -1; max_run = 0;
    @(negedge clk);
    change_in = amt; change_valid = 1'b1; eject_ack = hold;
    n = 0; age = 0; prev = 1'b0;
    while (busy_fall < 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (n == 1) begin change_valid = 1'b0; change_in = 8'd0; end
      if (n == cv_edge) begin change_valid = 1'b1; change_in = 8'd50; end
      else if (n == cv_edge + 1) begin change_valid = 1'b0; change_in = 8'd0; end
      if (eject_req) begin
        if (!prev) begin got_coins.push_back(eject); got_edges.push_back(n); age = 0; end
        age++;
        if (age > max_run) max_run = age;
      end else age = 0;
      prev = eject_req;
      eject_ack = hold || (eject_req && age > delay);
      if (done) begin done_cnt++; done_edge = n; end
      if (fault && fault_edge < 0) fault_edge = n;
      if (!busy) busy_fall = n;
    end
    eject_ack = 1'b0; change_valid = 1'b0;
    if (busy_fall < 0) begin
      checks++; errors++;
      $display("FAIL txn_budget amt=%0d: busy still high after %0d cycles", amt, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; change_valid = 1'b0; change_in = 8'd0; eject_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({eject_req, eject, busy, done, fault, remaining, coins_out} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h expected=0",
               {eject_req, eject, busy, done, fault, remaining, coins_out});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_req();
    int n;
    @(negedge clk);
    change_in = 8'd55; change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    n = 0;
    while (!eject_req && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (eject_req !== 1'b1) begin errors++; $display("FAIL midreq_wait eject_req=%b expected 1", eject_req); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({eject_req, eject, busy, done, fault, remaining, coins_out} !== 18'd0) begin
      errors++;
      $display("FAIL midreq_async_reset got=%h expected=0",
               {eject_req, eject, busy, done, fault, remaining, coins_out});
    end
    @(negedge clk);
    reset = 1'b0;
    run_txn(8'd10, 0, 1'b0, -1, 60);
    checks++;
    if (got_coins.size() != 1 || got_coins[0] !== 2'b10) begin
      errors++; $display("FAIL after_reset_coins n=%0d expected one 10 coin", got_coins.size());
    end
    checks++;
    if (done_cnt != 1 || coins_out !== 4'd1 || remaining !== 8'd0) begin
      errors++;
      $display("FAIL after_reset_result done=%0d coins=%0d rem=%0d expected 1/1/0", done_cnt, coins_out, remaining);
    end
  endtask

  task automatic test_payout_35();
    run_txn(8'd35, 0, 1'b1, -1, 60);
    model(35);
    checks++;
    if (got_coins != exp_coins) begin
      errors++; $display("FAIL p35_coins got=%p expected=%p", got_coins, exp_coins);
    end
    checks++;
    if (got_edges.size() != 3 || got_edges[0] != 2 || got_edges[1] != 5 || got_edges[2] != 8) begin
      errors++; $display("FAIL p35_edges got=%p expected 2,5,8", got_edges);
    end
    checks++;
    if (done_edge != 11 || done_cnt != 1 || busy_fall != 12) begin
      errors++;
      $display("FAIL p35_timing done_edge=%0d cnt=%0d busy_fall=%0d expected 11/1/12", done_edge, done_cnt, busy_fall);
    end
    checks++;
    if (coins_out !== 4'd3 || remaining !== 8'd0 || fault !== 1'b0) begin
      errors++; $display("FAIL p35_result coins=%0d rem=%0d fault=%b expected 3/0/0", coins_out, remaining, fault);
    end
  endtask

  task automatic test_residue_7();
    run_txn(8'd7, 0, 1'b0, -1, 60);
    checks++;
    if (got_coins.size() != 1 || got_coins[0] !== 2'b01) begin
      errors++; $display("FAIL p7_coins got=%p expected one 01", got_coins);
    end
    checks++;
    if (fault !== 1'b1 || remaining !== 8'd2 || coins_out !== 4'd1 || done_cnt != 0) begin
      errors++;
      $display("FAIL p7_result fault=%b rem=%0d coins=%0d done=%0d expected 1/2/1/0", fault, remaining, coins_out, done_cnt);
    end
    checks++;
    if (fault_edge != 5) begin errors++; $display("FAIL p7_fault_edge got=%0d expected 5", fault_edge); end
  endtask

  task automatic test_timeout();
    run_txn(8'd20, 100000, 1'b0, -1, 60);
    checks++;
    if (max_run != TO || got_coins.size() != 1) begin
      errors++; $display("FAIL timeout_req_len got=%0d reqs=%0d expected %0d/1", max_run, got_coins.size(), TO);
    end
    checks++;
    if (fault !== 1'b1 || remaining !== 8'd20 || coins_out !== 4'd0 || done_cnt != 0) begin
      errors++;
      $display("FAIL timeout_result fault=%b rem=%0d coins=%0d done=%0d expected 1/20/0/0", fault, remaining, coins_out, done_cnt);
    end
    checks++;
    if (fault_edge != TO + 2) begin errors++; $display("FAIL timeout_fault_edge got=%0d expected %0d", fault_edge, TO + 2); end
    run_txn(8'd5, 0, 1'b0, -1, 60);
    checks++;
    if (fault !== 1'b0 || got_coins.size() != 1 || got_coins[0] !== 2'b01 || done_cnt != 1) begin
      errors++;
      $display("FAIL timeout_recover fault=%b coins=%p done=%0d expected 0/one 01/1", fault, got_coins, done_cnt);
    end
  endtask

  task automatic test_payout_255();
    run_txn(8'd255, 2, 1'b0, 10, 200);
    model(255);
    checks++;
    if (got_coins != exp_coins) begin
      errors++; $display("FAIL p255_coins got=%p expected=%p", got_coins, exp_coins);
    end
    checks++;
    if (coins_out !== 4'd14 || remaining !== 8'd0 || fault !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL p255_result coins=%0d rem=%0d fault=%b done=%0d expected 14/0/0/1", coins_out, remaining, fault, done_cnt);
    end
    checks++;
    if (done_edge != 14 * 5 + 2) begin errors++; $display("FAIL p255_done_edge got=%0d expected %0d", done_edge, 14 * 5 + 2); end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || eject_req !== 1'b0) begin
      errors++; $display("FAIL p255_no_requeue busy=%b eject_req=%b expected 0/0", busy, eject_req);
    end
  endtask

  task automatic test_zero();
    int bad;
    bad = 0;
    @(negedge clk);
    change_in = 8'd0; change_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      change_valid = 1'b0;
      if (busy !== 1'b0 || done !== 1'b0 || eject_req !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL zero_ignored got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_random();
    int amt, d, k;
    for (int t = 0; t < 16; t++) begin
      amt = $urandom_range(1, 255);
      d   = $urandom_range(0, 3);
      run_txn(8'(amt), d, 1'b0, -1, 300);
      model(amt);
      k = exp_coins.size();
      checks++;
      if (got_coins != exp_coins) begin
        errors++; $display("FAIL rand_coins amt=%0d got=%p expected=%p", amt, got_coins, exp_coins);
      end
      checks++;
      if (remaining !== 8'(exp_residue) || coins_out !== 4'(k) || fault !== (exp_residue != 0)) begin
        errors++;
        $display("FAIL rand_result amt=%0d rem=%0d coins=%0d fault=%b expected %0d/%0d/%0b",
                 amt, remaining, coins_out, fault, exp_residue, k, exp_residue != 0);
      end
      checks++;
      if (done_cnt != ((exp_residue == 0) ? 1 : 0) || busy_fall != k * (3 + d) + 3) begin
        errors++;
        $display("FAIL rand_timing amt=%0d d=%0d done=%0d busy_fall=%0d expected %0d/%0d",
                 amt, d, done_cnt, busy_fall, (exp_residue == 0) ? 1 : 0, k * (3 + d) + 3);
      end
      $display("txn amt=%0d delay=%0d coins=%0d residue=%0d", amt, d, coins_out, remaining);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_req();
    test_payout_35();
    test_residue_7();
    test_timeout();
    test_payout_255();
    test_zero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream stage of the vending FSM: accepts a change amount and pays it out as physical coins through a coin hopper. Uses a greedy 20/10/5 decomposition and a request/acknowledge handshake per coin, with a timeout on the hopper. Reports completion, an unpayable residue, or a hopper fault. The coin encoding matches the vending FSM's coin input: 01=5, 10=10, 11=20.

## Interface
- TIMEOUT_CYCLES, 1000: maximum cycles `eject_req` may wait for `eject_ack` before faulting (≥1).
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- change_in  in  8  change amount, unsigned units; sampled only when `change_valid`=1 in IDLE.
- change_valid  in  1  one-cycle start strobe.
- eject_ack  in  1  hopper acknowledge; the current coin has been released.
- eject_req  out  1  hopper request; held until acknowledged or timed out.
- eject  out  2  coin to release; valid while `eject_req`=1, otherwise 00.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse on successful full payout.
- fault  out  1  sticky error flag: residue or timeout.
- remaining  out  8  amount still owed; holds the residue after a fault.
- coins_out  out  4  coins released in the current transaction.

## Operation
- Reset value is 0 for every output. State is IDLE, and the timeout counter is 0.
- States: IDLE, PICK, REQ, GAP, DONE, FAULT.
- **IDLE**
  - `change_valid`=1 and `change_in`≠0: load `remaining`=`change_in`, clear `coins_out` and `fault`, go to PICK.
  - `change_valid` with `change_in`=0: ignored, with no `done`.
  - `change_valid` in any other state: ignored, with no queuing.
- **PICK** (one cycle), registering the coin code:
  - `remaining`≥20 selects 11.
  - ≥10 selects 10.
  - ≥5 selects 01.
  - Then go to REQ.
  - `remaining`=0: go to DONE.
  - 0<`remaining`<5: go to FAULT (residue).
- **REQ**
  - Drive `eject_req`=1 with the registered code on `eject`.
  - Timeout counter increments each REQ cycle.
  - `eject_ack`=1 sampled: `remaining` -= coin value (5/10/20), `coins_out`+=1, clear counter, go to GAP.
  - Counter reaches TIMEOUT_CYCLES-1 without ack: go to FAULT. `remaining` and `coins_out` are left unchanged.
  - Ack and timeout in the same cycle: ack wins.
- **GAP**: one cycle with `eject_req`=0 and `eject`=00, then go to PICK. This guarantees a low cycle between requests.
- **DONE**: `done`=1 for this single cycle, then go to IDLE.
- **FAULT**: `fault` is set and stays high until the next accepted `change_valid` or reset. Stays one cycle, then goes to IDLE.
- `eject_ack` outside REQ is ignored.
- Subtraction cannot underflow, because coins are only chosen when ≤ `remaining`.
- `coins_out` maximum is 14 (255 = 12×20 + 10 + 5), so 4 bits suffice.
- Reset mid-transaction:
  - `eject_req` drops asynchronously.
  - The transaction is abandoned and not resumed.

## Timing
- All outputs are registered and reflect the current state.
- Cycle numbering: n = state after rising edge n; `change_valid` is sampled at edge 0.
- Edge 1 is PICK with `busy`=1 and `remaining` loaded. The first `eject_req` is high at edge 2.
- With ack returned in the first REQ cycle, each coin costs 3 cycles (PICK, REQ, GAP).
- Payout of k coins with immediate ack:
  - `done` is high at edge 3k+2.
  - `busy` falls at edge 3k+3.
- Timeout: `eject_req` stays high for exactly TIMEOUT_CYCLES cycles, then FAULT in the next cycle.
- `eject_ack` may be held high. Each REQ entry consumes exactly one ack, because GAP intervenes.

## Test plan
- Reset mid-REQ (`change_in`=55, reset while `eject_req`=1):
  - All outputs are 0 immediately.
  - A later `change_valid` with 10 pays a single 10 coin normally.
- Payout 35 with ack tied high:
  - `eject` sequence is 11, 10, 01 at edges 2, 5, 8.
  - `done` at edge 11, `coins_out`=3, `remaining`=0, `fault`=0.
- Payout 7:
  - One 01 coin.
  - Then `fault`=1, `remaining`=2, `coins_out`=1, no `done`.
- Timeout with TIMEOUT_CYCLES=8 and ack never asserted on `change_in`=20:
  - `eject_req` high for 8 cycles, then `fault`=1, `remaining`=20, `coins_out`=0.
  - A following `change_valid` with 5 clears `fault` and pays one 01.
- Payout 255 with ack delayed 2 cycles per request:
  - 12×11, then 10, then 01.
  - `coins_out`=14, `done` pulse.
  - A second `change_valid` pulsed while busy is ignored (no extra coins).
- `change_valid` with `change_in`=0:
  - No state change: `busy`, `done` and `eject_req` all stay 0.
